// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter slice.
package pc_pkg;

  typedef enum logic {
    PC_RUN,
    PC_HALT
  } pc_state_t;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_JAL,
    SEL_JALR
  } pc_sel_t;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/pc_target.sv
// Next-PC target generation: control priority encode, address adders,
// JALR bit0 clear and misaligned-target detection. Purely combinational.
module pc_target
  import pc_pkg::*;
#(
  parameter int unsigned ALEN = 32
) (
  input  logic [ALEN-1:0] pc_i,
  input  logic [ALEN-1:0] imm_i,
  input  logic [ALEN-1:0] rs1_i,
  input  logic            brnch_i,
  input  logic            jmp_i,
  input  logic            jmplr_i,
  output pc_sel_t         sel_o,
  output logic [ALEN-1:0] plus4_o,
  output logic [ALEN-1:0] target_o,
  output logic            misalign_o
);

  logic [ALEN-1:0] rel_sum;
  logic [ALEN-1:0] jalr_sum;

  assign plus4_o  = pc_i + ALEN'(INSTR_BYTES);
  assign rel_sum  = pc_i + imm_i;
  assign jalr_sum = rs1_i + imm_i;

  // Priority encode the control inputs: jmplr > jmp > brnch > sequential.
  always_comb begin
    sel_o = SEL_SEQ;
    if (jmplr_i) begin
      sel_o = SEL_JALR;
    end else if (jmp_i) begin
      sel_o = SEL_JAL;
    end else if (brnch_i) begin
      sel_o = SEL_BR;
    end
  end

  // Select the target; JALR drops bit0 before the alignment test.
  always_comb begin
    target_o = plus4_o;
    unique case (sel_o)
      SEL_SEQ:  target_o = plus4_o;
      SEL_BR:   target_o = rel_sum;
      SEL_JAL:  target_o = rel_sum;
      SEL_JALR: target_o = {jalr_sum[ALEN-1:1], 1'b0};
      default:  target_o = plus4_o;
    endcase
  end

  assign misalign_o = |target_o[1:0];

endmodule

// File: rtl/pc_unit.sv
// Program counter with branch/JAL/JALR, stall, misalign-to-HALT and resume.
// Optional retired-instruction counter enabled by defining PC_INSTRET_EN.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     ALEN      = 32,
  parameter logic [ALEN-1:0] RESET_VEC = '0,
  parameter logic [ALEN-1:0] TRAP_VEC  = ALEN'('h100),
  parameter int unsigned     CNTW      = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            brnch,
  input  logic            jmp,
  input  logic            jmplr,
  input  logic [ALEN-1:0] imm,
  input  logic [ALEN-1:0] rs1,
  input  logic            resume,
  output logic [ALEN-1:0] pcOut,
  output logic [ALEN-1:0] pcPlus4,
  output logic            halted,
  output logic            misalign,
`ifdef PC_INSTRET_EN
  output logic [CNTW-1:0] instret,
`endif
  output logic [ALEN-1:0] epc
);

  // Elaboration-time sanity checks on the configuration.
  if (ALEN < 4) begin : g_chk_alen
    $error("pc_unit: ALEN must be at least 4");
  end
  if (CNTW < 1) begin : g_chk_cntw
    $error("pc_unit: CNTW must be at least 1");
  end
  if ((RESET_VEC[1:0] != 2'b00) || (TRAP_VEC[1:0] != 2'b00)) begin : g_chk_vec
    $error("pc_unit: RESET_VEC and TRAP_VEC must be 4-byte aligned");
  end

  pc_state_t       state_q, state_d;
  logic [ALEN-1:0] pc_q, pc_d;
  logic [ALEN-1:0] epc_q, epc_d;
  logic            mis_q, mis_d;

  pc_sel_t         tgt_sel;
  logic [ALEN-1:0] tgt_plus4;
  logic [ALEN-1:0] tgt_addr;
  logic            tgt_mis;

  pc_target #(
    .ALEN(ALEN)
  ) u_target (
    .pc_i      (pc_q),
    .imm_i     (imm),
    .rs1_i     (rs1),
    .brnch_i   (brnch),
    .jmp_i     (jmp),
    .jmplr_i   (jmplr),
    .sel_o     (tgt_sel),
    .plus4_o   (tgt_plus4),
    .target_o  (tgt_addr),
    .misalign_o(tgt_mis)
  );

  // Next-state logic: advance, fault into HALT, or leave HALT on resume.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    mis_d   = 1'b0;
    unique case (state_q)
      PC_RUN: begin
        if (!stall) begin
          if (tgt_mis) begin
            epc_d   = tgt_addr;
            mis_d   = 1'b1;
            state_d = PC_HALT;
          end else begin
            pc_d = tgt_addr;
          end
        end
      end
      PC_HALT: begin
        if (resume) begin
          pc_d    = TRAP_VEC;
          state_d = PC_RUN;
        end
      end
      default: state_d = PC_RUN;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= PC_RUN;
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      mis_q   <= mis_d;
    end
  end

`ifdef PC_INSTRET_EN
  logic [CNTW-1:0] cnt_q;

  // Count every RUN edge that actually advances the PC.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if ((state_q == PC_RUN) && !stall && !tgt_mis) begin
      cnt_q <= cnt_q + CNTW'(1);
    end
  end

  assign instret = cnt_q;
`endif

  assign pcOut    = pc_q;
  assign pcPlus4  = tgt_plus4;
  assign halted   = (state_q == PC_HALT);
  assign misalign = mis_q;
  assign epc      = epc_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed steps followed by random stimulus,
// each edge compared against a behavioural model of the PC rules.
module tb_pc_unit;

  localparam logic [31:0] RST_V  = 32'h0;
  localparam logic [31:0] TRAP_V = 32'h100;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        brnch = 1'b0;
  logic        jmp = 1'b0;
  logic        jmplr = 1'b0;
  logic [31:0] imm = '0;
  logic [31:0] rs1 = '0;
  logic        resume = 1'b0;
  logic [31:0] pcOut;
  logic [31:0] pcPlus4;
  logic        halted;
  logic        misalign;
  logic [31:0] epc;
`ifdef PC_INSTRET_EN
  logic [31:0] instret;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic        m_halt;
  logic        m_mis;
  logic [31:0] m_ir;

  pc_unit #(
    .ALEN     (32),
    .RESET_VEC(RST_V),
    .TRAP_VEC (TRAP_V),
    .CNTW     (32)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .stall   (stall),
    .brnch   (brnch),
    .jmp     (jmp),
    .jmplr   (jmplr),
    .imm     (imm),
    .rs1     (rs1),
    .resume  (resume),
    .pcOut   (pcOut),
    .pcPlus4 (pcPlus4),
    .halted  (halted),
    .misalign(misalign),
`ifdef PC_INSTRET_EN
    .instret (instret),
`endif
    .epc     (epc)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, act, exp);
    end
  endtask

  // Architectural rules for one clock edge, applied to the model.
  task automatic model_edge();
    logic [31:0] t;
    if (!reset) begin
      m_pc = RST_V; m_epc = '0; m_halt = 1'b0; m_mis = 1'b0; m_ir = '0;
    end else if (m_halt) begin
      m_mis = 1'b0;
      if (resume) begin
        m_pc = TRAP_V;
        m_halt = 1'b0;
      end
    end else if (stall) begin
      m_mis = 1'b0;
    end else begin
      if (jmplr)      t = (rs1 + imm) & ~32'h1;
      else if (jmp)   t = m_pc + imm;
      else if (brnch) t = m_pc + imm;
      else            t = m_pc + 32'd4;
      if ((t % 4) != 0) begin
        m_epc = t; m_halt = 1'b1; m_mis = 1'b1;
      end else begin
        m_pc = t; m_mis = 1'b0; m_ir = m_ir + 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pcOut"}, pcOut, m_pc);
    chk({tag, ".pcPlus4"}, pcPlus4, m_pc + 32'd4);
    chk({tag, ".halted"}, {31'b0, halted}, {31'b0, m_halt});
    chk({tag, ".misalign"}, {31'b0, misalign}, {31'b0, m_mis});
    chk({tag, ".epc"}, epc, m_epc);
`ifdef PC_INSTRET_EN
    chk({tag, ".instret"}, instret, m_ir);
`endif
  endtask

  task automatic step(input string tag, input logic r, input logic st, input logic b,
                      input logic j, input logic jr, input logic res,
                      input logic [31:0] im, input logic [31:0] rs);
    reset = r; stall = st; brnch = b; jmp = j; jmplr = jr; resume = res;
    imm = im; rs1 = rs;
    @(posedge clock);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    m_pc = '0; m_epc = '0; m_halt = 1'b0; m_mis = 1'b0; m_ir = '0;

    // reset
    step("rst0", 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step("rst1", 0, 1, 1, 1, 1, 1, 32'h6, 32'h3);
    chk("rst_pc", pcOut, 32'h0);
    chk("rst_halt", {31'b0, halted}, 32'h0);

    // sequential flow
    step("seq1", 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step("seq2", 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step("seq3", 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("seq_pc", pcOut, 32'hC);
`ifdef PC_INSTRET_EN
    chk("seq_ir", instret, 32'd3);
`endif

    // branch backwards, then branch+jmp together
    step("jmp20", 1, 0, 0, 1, 0, 0, 32'h14, 32'h0);
    chk("jmp20_pc", pcOut, 32'h20);
    step("br", 1, 0, 1, 0, 0, 0, 32'hFFFF_FFF0, 32'h0);
    chk("br_pc", pcOut, 32'h10);
    step("jmp20b", 1, 0, 0, 1, 0, 0, 32'h10, 32'h0);
    step("brjmp", 1, 0, 1, 1, 0, 0, 32'hFFFF_FFF0, 32'h0);
    chk("brjmp_pc", pcOut, 32'h10);

    // JALR with bit0 clear, and priority over branch
    step("jalr", 1, 0, 0, 0, 1, 0, 32'h4, 32'h41);
    chk("jalr_pc", pcOut, 32'h44);
    step("jalr_br", 1, 0, 1, 0, 1, 0, 32'h4, 32'h41);
    chk("jalr_br_pc", pcOut, 32'h44);

    // stall holds everything
    step("stall1", 1, 1, 0, 1, 0, 0, 32'h8, 32'h0);
    step("stall2", 1, 1, 0, 1, 0, 0, 32'h8, 32'h0);
    chk("stall_pc", pcOut, 32'h44);
    step("unstall", 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("unstall_pc", pcOut, 32'h48);

    // resume in RUN ignored
    step("res_run", 1, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    chk("res_run_pc", pcOut, 32'h4C);

    // misalign, HALT, recovery
    step("to10", 1, 0, 0, 1, 0, 0, 32'h10 - 32'h4C, 32'h0);
    step("mis", 1, 0, 0, 1, 0, 0, 32'h6, 32'h0);
    chk("mis_pc", pcOut, 32'h10);
    chk("mis_epc", epc, 32'h16);
    chk("mis_pulse", {31'b0, misalign}, 32'h1);
    chk("mis_halt", {31'b0, halted}, 32'h1);
    step("halt_st", 1, 1, 1, 0, 0, 0, 32'h8, 32'h0);
    chk("halt_pulse_end", {31'b0, misalign}, 32'h0);
    step("halt_br", 1, 0, 1, 1, 1, 0, 32'h8, 32'h8);
    chk("halt_pc", pcOut, 32'h10);
    step("resume", 1, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    chk("resume_pc", pcOut, 32'h100);
    chk("resume_halt", {31'b0, halted}, 32'h0);
    chk("resume_epc", epc, 32'h16);

    // wrap around the top of the address space
    step("top", 1, 0, 0, 0, 1, 0, 32'h0, 32'hFFFF_FFFC);
    chk("top_pc", pcOut, 32'hFFFF_FFFC);
    chk("top_plus4", pcPlus4, 32'h0);
    step("wrap", 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("wrap_pc", pcOut, 32'h0);

    // reset while halted
    step("mis2", 1, 0, 1, 0, 0, 0, 32'h2, 32'h0);
    chk("mis2_halt", {31'b0, halted}, 32'h1);
    step("rst_halt", 0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    chk("rst_halt_pc", pcOut, 32'h0);
    chk("rst_halt_h", {31'b0, halted}, 32'h0);

    // random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ri;
      logic [31:0] rr;
      ri = $urandom;
      rr = $urandom;
      if ($urandom_range(0, 3) != 0) ri[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) rr[1:0] = 2'b00;
      step("rand",
           ($urandom_range(0, 39) != 0),
           ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0),
           ri, rr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program counter for the RISC-V core; next generation of the increment-only PC.
- Generates the next instruction address for sequential flow, conditional branch, JAL and JALR.
- Supports pipeline stall, misaligned-target detection and a HALT state that is left by a resume handshake.
- Sits between the decode/branch-compare logic and the instruction memory address port.

Parameters:
- ALEN, 32, address width in bits (min 4).
- RESET_VEC, 0, pcOut value after reset (ALEN bits, 4-byte aligned).
- TRAP_VEC, 'h100, pcOut loaded on resume from HALT (ALEN bits, 4-byte aligned).
- CNTW, 32, instret counter width (used only with PC_INSTRET_EN).

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  hold PC; all control inputs ignored while high.
- brnch  in  1  conditional branch taken; target = pcOut + imm.
- jmp  in  1  JAL; target = pcOut + imm.
- jmplr  in  1  JALR; target = (rs1 + imm) with bit0 cleared.
- imm  in  ALEN  sign-extended offset from decode.
- rs1  in  ALEN  register-file operand for JALR.
- resume  in  1  leave HALT; honoured only in HALT.
- pcOut  out  ALEN  current instruction address (registered).
- pcPlus4  out  ALEN  pcOut + 4 (combinational link address for rd).
- halted  out  1  high while in HALT.
- misalign  out  1  one-cycle pulse on the edge that enters HALT.
- epc  out  ALEN  faulting target address (registered).
- instret  out  CNTW  retired-instruction count (PC_INSTRET_EN only).

Behaviour:
- Reset (reset==0 at posedge):
  - pcOut=RESET_VEC, epc=0, state=RUN, halted=0, misalign=0, instret=0.
  - Reset overrides all other inputs, including mid-HALT.
- States are RUN and HALT.
- Control priority in RUN with stall=0: jmplr > jmp > brnch > sequential (pcOut+4).
  - Multiple asserted controls are legal; the highest priority one wins.
- All arithmetic is modulo 2^ALEN; carries are discarded.
  - Example: pcOut = 2^ALEN-4 with no control wraps to 0.
- Misaligned target (RUN, stall=0, selected target[1:0]!=0 after the JALR bit0 clear):
  - Next edge: pcOut holds its value, epc=target, state -> HALT.
  - halted=1 from that edge.
  - misalign=1 for exactly that one cycle.
- Sequential +4 can never misalign, because RESET_VEC and TRAP_VEC are aligned.
- RUN with stall=1: pcOut, state and instret all hold; brnch/jmp/jmplr are ignored.
- HALT:
  - pcOut holds; stall and controls are ignored.
  - resume=1 -> next edge pcOut=TRAP_VEC, state=RUN, halted=0.
  - epc is retained until the next fault.
- resume in RUN is ignored.
- Latency: one clock from input to pcOut change; pcPlus4 follows pcOut combinationally.

Optional Feature:
- Macro PC_INSTRET_EN.
- Defined:
  - instret port exists.
  - Increments by 1 on each RUN edge with stall=0 and no misalign; wraps modulo 2^CNTW.
  - Holds in HALT and during stall; cleared by reset.
- Undefined: instret port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package pc_pkg:
  - pc_state_t enum {PC_RUN, PC_HALT}.
  - pc_sel_t enum {SEL_SEQ, SEL_BR, SEL_JAL, SEL_JALR}.
  - Constant INSTR_BYTES=4.
- One sub-module pc_target (combinational):
  - Priority encode into pc_sel_t.
  - Adders for pcOut+4, pcOut+imm and rs1+imm.
  - JALR bit0 clear and misalign flag.
- pc_unit holds the FSM, pcOut/epc registers and the optional counter.

Test Plan:
- Reset then 3 idle edges -> pcOut 0x0, 0x4, 0x8, 0xC; halted=0; instret=3 (with PC_INSTRET_EN).
- pcOut=0x20, brnch=1, imm=0xFFFFFFF0 -> pcOut=0x10; with jmp=1 also high and imm same, result is still 0x10.
- jmplr=1, rs1=0x41, imm=0x4 -> pcOut=0x44 (bit0 cleared); jmplr and brnch together -> JALR target wins.
- stall=1 for 2 cycles with jmp=1, imm=0x8 -> pcOut unchanged, instret unchanged; after stall drops, pcOut+4.
- Misalign and recovery:
  - jmp=1, imm=0x6 at pcOut=0x10 -> pcOut stays 0x10, epc=0x16, misalign pulses 1 cycle, halted=1.
  - stall/brnch ignored in HALT.
  - resume=1 -> pcOut=0x100, halted=0.
- pcOut=0xFFFFFFFC sequential -> 0x0; reset=0 asserted while halted -> pcOut=0x0, halted=0 next edge.
